// File: rtl/frog_pkg.sv
// Shared grid geometry and lane helpers for the frog game blocks.
package frog_pkg;

  localparam int GRID_COLS    = 20;
  localparam int GRID_ROWS    = 15;
  localparam int NUM_LANES    = 5;
  localparam int NUM_CARS     = 10;
  localparam int LANE_ROW0    = 3;
  localparam int LANE_PITCH   = 2;
  localparam int COL_W        = 5;
  localparam int ROW_W        = 4;
  localparam int CNT_W        = 24;
  localparam int CAR_SPACING  = 10;
  localparam int LANE_X0_STEP = 3;

  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Screen row occupied by a given lane.
  function automatic row_t lane_row(input int lane);
    return row_t'(LANE_ROW0 + LANE_PITCH * lane);
  endfunction

endpackage

// File: rtl/traffic_controller_lane_mover.sv
// One traffic lane: step counter plus the two car columns that share it.
module lane_mover
  import frog_pkg::*;
#(
  parameter int   LANE        = 0,
  parameter dir_e DIR         = DIR_RIGHT,
  parameter int   INIT_X      = 0,
  parameter int   COLS        = 20,
  parameter int   BASE_PERIOD = 6_000_000,
  parameter int   LANE_SKEW   = 1_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] level,
  output col_t       x_a,
  output col_t       x_b
);

  localparam int unsigned LANE_BASE = BASE_PERIOD + LANE * LANE_SKEW;
  localparam col_t        X_MAX     = col_t'(COLS - 1);
  localparam col_t        INIT_A    = col_t'(INIT_X % COLS);
  localparam col_t        INIT_B    = col_t'((INIT_X + CAR_SPACING) % COLS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  col_t             xa_q, xa_d, xb_q, xb_d;
  logic [31:0]      period;
  logic [31:0]      last_cnt;
  logic             terminal;

  // Advance one column in the lane's direction, wrapping at the grid edges.
  function automatic col_t wrap_step(input col_t x);
    if (DIR == DIR_RIGHT) return (x == X_MAX) ? '0 : x + col_t'(1);
    else                  return (x == '0) ? X_MAX : x - col_t'(1);
  endfunction

  // Period shrinks with level; >= lets a shortened period fire immediately.
  always_comb begin
    period   = 32'(LANE_BASE) >> level;
    last_cnt = (period == '0) ? '0 : period - 32'd1;
    terminal = ({{(32-CNT_W){1'b0}}, cnt_q} >= last_cnt);
    cnt_d    = cnt_q;
    xa_d     = xa_q;
    xb_d     = xb_q;
    if (run) begin
      if (terminal) begin
        cnt_d = '0;
        xa_d  = wrap_step(xa_q);
        xb_d  = wrap_step(xb_q);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and car column registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      xa_q  <= INIT_A;
      xb_q  <= INIT_B;
    end else begin
      cnt_q <= cnt_d;
      xa_q  <= xa_d;
      xb_q  <= xb_d;
    end
  end

  assign x_a = xa_q;
  assign x_b = xb_q;

endmodule

// File: rtl/traffic_controller.sv
// Car position generator: five lanes of two cars plus difficulty level tracking.
module traffic_controller
  import frog_pkg::*;
#(
  parameter int GRID_COLS   = 20,
  parameter int BASE_PERIOD = 6_000_000,
  parameter int LANE_SKEW   = 1_500_000,
  parameter int MAX_LEVEL   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       frog_at_top,
  input  logic       collision_detected,
  output logic [4:0] car1_x,
  output logic [4:0] car2_x,
  output logic [4:0] car3_x,
  output logic [4:0] car4_x,
  output logic [4:0] car5_x,
  output logic [4:0] car6_x,
  output logic [4:0] car7_x,
  output logic [4:0] car8_x,
  output logic [4:0] car9_x,
  output logic [4:0] car10_x,
  output logic [3:0] car1_y,
  output logic [3:0] car2_y,
  output logic [3:0] car3_y,
  output logic [3:0] car4_y,
  output logic [3:0] car5_y,
  output logic [3:0] car6_y,
  output logic [3:0] car7_y,
  output logic [3:0] car8_y,
  output logic [3:0] car9_y,
  output logic [3:0] car10_y,
  output logic [1:0] level,
  output logic       level_up
);

  localparam logic [1:0] MAX_LVL = 2'(MAX_LEVEL);

  col_t       lane_xa [NUM_LANES];
  col_t       lane_xb [NUM_LANES];

  logic       top_q, top_d;
  logic       coll_q, coll_d;
  logic [1:0] level_q, level_d;
  logic       level_up_q, level_up_d;
  logic       top_rise, coll_rise;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_mover #(
      .LANE        (l),
      .DIR         ((l % 2 == 0) ? DIR_RIGHT : DIR_LEFT),
      .INIT_X      (LANE_X0_STEP * l),
      .COLS        (GRID_COLS),
      .BASE_PERIOD (BASE_PERIOD),
      .LANE_SKEW   (LANE_SKEW)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .level (level_q),
      .x_a   (lane_xa[l]),
      .x_b   (lane_xb[l])
    );
  end

  // Level update: collision edge clears, top edge climbs with saturation.
  always_comb begin
    top_d      = frog_at_top;
    coll_d     = collision_detected;
    top_rise   = frog_at_top & ~top_q;
    coll_rise  = collision_detected & ~coll_q;
    level_d    = level_q;
    level_up_d = 1'b0;
    if (coll_rise) begin
      level_d = '0;
    end else if (top_rise && (level_q < MAX_LVL)) begin
      level_d    = level_q + 2'd1;
      level_up_d = 1'b1;
    end
  end

  // Edge-detect history and level state.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q      <= 1'b0;
      coll_q     <= 1'b0;
      level_q    <= '0;
      level_up_q <= 1'b0;
    end else begin
      top_q      <= top_d;
      coll_q     <= coll_d;
      level_q    <= level_d;
      level_up_q <= level_up_d;
    end
  end

  assign level    = level_q;
  assign level_up = level_up_q;

  assign car1_x  = lane_xa[0];
  assign car2_x  = lane_xb[0];
  assign car3_x  = lane_xa[1];
  assign car4_x  = lane_xb[1];
  assign car5_x  = lane_xa[2];
  assign car6_x  = lane_xb[2];
  assign car7_x  = lane_xa[3];
  assign car8_x  = lane_xb[3];
  assign car9_x  = lane_xa[4];
  assign car10_x = lane_xb[4];

  assign car1_y  = lane_row(0);
  assign car2_y  = lane_row(0);
  assign car3_y  = lane_row(1);
  assign car4_y  = lane_row(1);
  assign car5_y  = lane_row(2);
  assign car6_y  = lane_row(2);
  assign car7_y  = lane_row(3);
  assign car8_y  = lane_row(3);
  assign car9_y  = lane_row(4);
  assign car10_y = lane_row(4);

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller with short periods (base 8, skew 2).
module tb_traffic_controller;

  logic       clk = 1'b0;
  logic       reset, run, frog_at_top, collision_detected;
  logic [4:0] car1_x, car2_x, car3_x, car4_x, car5_x;
  logic [4:0] car6_x, car7_x, car8_x, car9_x, car10_x;
  logic [3:0] car1_y, car2_y, car3_y, car4_y, car5_y;
  logic [3:0] car6_y, car7_y, car8_y, car9_y, car10_y;
  logic [1:0] level;
  logic       level_up;

  int tests  = 0;
  int failed = 0;

  traffic_controller #(
    .GRID_COLS   (20),
    .BASE_PERIOD (8),
    .LANE_SKEW   (2),
    .MAX_LEVEL   (3)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .run                (run),
    .frog_at_top        (frog_at_top),
    .collision_detected (collision_detected),
    .car1_x  (car1_x),  .car2_x (car2_x), .car3_x (car3_x), .car4_x (car4_x),
    .car5_x  (car5_x),  .car6_x (car6_x), .car7_x (car7_x), .car8_x (car8_x),
    .car9_x  (car9_x),  .car10_x(car10_x),
    .car1_y  (car1_y),  .car2_y (car2_y), .car3_y (car3_y), .car4_y (car4_y),
    .car5_y  (car5_y),  .car6_y (car6_y), .car7_y (car7_y), .car8_y (car8_y),
    .car9_y  (car9_y),  .car10_y(car10_y),
    .level    (level),
    .level_up (level_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clean frog_at_top pulse with checks of level and the single-cycle pulse.
  task automatic top_pulse(input string tag, input logic [1:0] exp_lvl, input logic exp_up);
    frog_at_top = 1'b1;
    cyc(1);
    check({tag, "_level"}, level, exp_lvl);
    check({tag, "_up"}, level_up, exp_up);
    cyc(1);
    check({tag, "_held_level"}, level, exp_lvl);
    check({tag, "_up_drop"}, level_up, 1'b0);
    frog_at_top = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; frog_at_top = 1'b0; collision_detected = 1'b0;
    cyc(3);

    // Reset state
    check("rst_c1x", car1_x, 0);   check("rst_c2x", car2_x, 10);
    check("rst_c3x", car3_x, 3);   check("rst_c4x", car4_x, 13);
    check("rst_c5x", car5_x, 6);   check("rst_c6x", car6_x, 16);
    check("rst_c7x", car7_x, 9);   check("rst_c8x", car8_x, 19);
    check("rst_c9x", car9_x, 12);  check("rst_c10x", car10_x, 2);
    check("c1y", car1_y, 3);  check("c2y", car2_y, 3);
    check("c3y", car3_y, 5);  check("c4y", car4_y, 5);
    check("c5y", car5_y, 7);  check("c6y", car6_y, 7);
    check("c7y", car7_y, 9);  check("c8y", car8_y, 9);
    check("c9y", car9_y, 11); check("c10y", car10_y, 11);
    check("rst_level", level, 0);
    check("rst_level_up", level_up, 0);

    // Basic stepping at level 0
    reset = 1'b0; run = 1'b1;
    cyc(7);  check("l0_pre_step", car1_x, 0);
    cyc(1);  check("l0_step1_c1", car1_x, 1);  check("l0_step1_c2", car2_x, 11);
    cyc(2);  check("l1_step1_c3", car3_x, 2);  check("l1_step1_c4", car4_x, 12);
    cyc(6);  check("l0_step2_c1", car1_x, 2);  check("l2_step1_c5", car5_x, 7);
    check("l3_step1_c7", car7_x, 8); check("l3_step1_c8", car8_x, 18);
    check("l4_step1_c9", car9_x, 13); check("l4_step1_c10", car10_x, 3);

    // Wrap-around: lane 1 passes 0 -> 19, lane 0 passes 19 -> 0
    cyc(24); check("l1_wrap_c3", car3_x, 19); check("l1_wrap_c4", car4_x, 9);
    cyc(112); check("l0_at19_c1", car1_x, 19); check("l0_at19_c2", car2_x, 9);
    cyc(8);  check("l0_wrap_c1", car1_x, 0);   check("l0_wrap_c2", car2_x, 10);

    // Fresh start for level tests
    run = 1'b0; reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);

    top_pulse("top1", 2'd1, 1'b1);
    run = 1'b1;
    cyc(3);  check("lv1_pre", car1_x, 0);
    cyc(1);  check("lv1_step", car1_x, 1);
    run = 1'b0;

    top_pulse("top2", 2'd2, 1'b1);
    run = 1'b1;
    cyc(1);  check("lv2_pre", car1_x, 1); check("lv2_shrink_c9", car9_x, 13);
    cyc(1);  check("lv2_step", car1_x, 2);
    run = 1'b0;

    top_pulse("top3", 2'd3, 1'b1);
    run = 1'b1;
    cyc(1);  check("lv3_step_a", car1_x, 3); check("lv3_c9", car9_x, 14);
    cyc(1);  check("lv3_step_b", car1_x, 4);
    run = 1'b0;

    top_pulse("top4_sat", 2'd3, 1'b0);

    // Collision alone clears level, no pulse
    collision_detected = 1'b1;
    cyc(1);  check("coll_level", level, 0); check("coll_up", level_up, 0);
    collision_detected = 1'b0;
    cyc(1);

    top_pulse("top5", 2'd1, 1'b1);
    top_pulse("top6", 2'd2, 1'b1);

    // Simultaneous edges: collision wins
    frog_at_top = 1'b1; collision_detected = 1'b1;
    cyc(1);  check("both_level", level, 0); check("both_up", level_up, 0);
    check("both_pos", car1_x, 4);
    frog_at_top = 1'b0; collision_detected = 1'b0;
    cyc(1);  check("both_up_after", level_up, 0);

    // Run freeze mid-count at level 0 (lane 0 counter at 0, car1 at 4)
    run = 1'b1;
    cyc(5);
    run = 1'b0;
    cyc(20); check("freeze_c1", car1_x, 4);
    run = 1'b1;
    cyc(2);  check("resume_pre", car1_x, 4);
    cyc(1);  check("resume_step", car1_x, 5);

    // Reset with a step pending overrides run and a top edge
    run = 1'b0; reset = 1'b1;
    cyc(1);
    reset = 1'b0; run = 1'b1;
    cyc(13); check("pre_rst_c1", car1_x, 1); check("pre_rst_c3", car3_x, 2);
    reset = 1'b1; frog_at_top = 1'b1;
    cyc(1);  check("mid_rst_c1", car1_x, 0); check("mid_rst_c3", car3_x, 3);
    check("mid_rst_c8", car8_x, 19); check("mid_rst_c10", car10_x, 2);
    check("mid_rst_level", level, 0); check("mid_rst_up", level_up, 0);
    frog_at_top = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(7);  check("post_rst_pre", car1_x, 0);
    cyc(1);  check("post_rst_step", car1_x, 1);
    check("post_rst_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
